// File: rtl/enemy_motion_ctrl_if.sv
// Bundle of per-frame control inputs and sprite-position outputs for enemy_motion_ctrl.
// master drives the video timing/game events; slave is the controller itself.
interface enemy_motion_ctrl_if;
    logic       start;
    logic       collision;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic [9:0] offset_x;
    logic [9:0] offset_y;
    logic       active;
    logic       frozen;
    logic [7:0] respawn_count;

    modport master (
        output start, collision, hcount, vcount,
        input  offset_x, offset_y, active, frozen, respawn_count
    );

    modport slave (
        input  start, collision, hcount, vcount,
        output offset_x, offset_y, active, frozen, respawn_count
    );
endinterface

// File: rtl/enemy_motion_ctrl.sv
// Enemy sprite motion: lane spawn, per-frame scroll, respawn and collision freeze.
// Define ENEMY_SPEEDUP_EN to ramp speed (adds SPEED_MAX / SPEEDUP_EVERY parameters).
module enemy_motion_ctrl #(
    parameter int unsigned LANES         = 3,
    parameter int unsigned LANE_BASE     = 160,
    parameter int unsigned LANE_STEP     = 120,
    parameter int unsigned Y_LIMIT       = 480,
    parameter int unsigned SPEED_INIT    = 2,
`ifdef ENEMY_SPEEDUP_EN
    parameter int unsigned SPEED_MAX     = 8,
    parameter int unsigned SPEEDUP_EVERY = 4,
`endif
    parameter int unsigned FREEZE_FRAMES = 60,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input logic               clk,
    input logic               reset,
    enemy_motion_ctrl_if.slave bus
);
    localparam int FCW = $clog2(FREEZE_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, SPAWN, MOVE, FREEZE} state_t;

    state_t         state_q, state_d;
    logic           frame_tick;
    logic [7:0]     lfsr_q;
    logic [9:0]     offset_x_q, offset_x_d;
    logic [9:0]     offset_y_q, offset_y_d;
    logic           active_q, active_d;
    logic           frozen_q, frozen_d;
    logic [7:0]     count_q, count_d;
    logic [1:0]     prev_lane_q, prev_lane_d;
    logic [FCW-1:0] freeze_cnt_q, freeze_cnt_d;
    logic [3:0]     speed;
    logic [1:0]     lane_raw, lane_pick;
    logic [10:0]    y_sum;

    // One pulse per frame, a clock after the scan passes the visible corner.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) frame_tick <= 1'b0;
        else       frame_tick <= (bus.hcount == 10'd640) && (bus.vcount == 10'd480);
    end

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Fold the 2-bit draw into range, then never repeat the previous lane.
    always_comb begin
        lane_raw = lfsr_q[1:0];
        if (32'(lane_raw) >= LANES) lane_raw = 2'(32'(lane_raw) - LANES);
        lane_pick = lane_raw;
        if (lane_pick == prev_lane_q) lane_pick = 2'((32'(lane_pick) + 1) % LANES);
    end

    assign y_sum = {1'b0, offset_y_q} + {7'b0, speed};

    // NOTE: every variable gets its default first, so no branch can infer a latch.
    always_comb begin
        state_d      = state_q;
        offset_x_d   = offset_x_q;
        offset_y_d   = offset_y_q;
        active_d     = active_q;
        frozen_d     = frozen_q;
        count_d      = count_q;
        prev_lane_d  = prev_lane_q;
        freeze_cnt_d = freeze_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = SPAWN;
            end
            SPAWN: begin
                if (frame_tick) begin
                    offset_x_d  = 10'(LANE_BASE + 32'(lane_pick) * LANE_STEP);
                    offset_y_d  = '0;
                    active_d    = 1'b1;
                    prev_lane_d = lane_pick;
                    state_d     = MOVE;
                end
            end
            MOVE: begin
                // Collision beats a coincident frame tick: the enemy stops where it is.
                if (bus.collision) begin
                    state_d      = FREEZE;
                    frozen_d     = 1'b1;
                    freeze_cnt_d = FCW'(FREEZE_FRAMES);
                end else if (frame_tick) begin
                    if (y_sum >= 11'(Y_LIMIT)) begin
                        active_d   = 1'b0;
                        offset_y_d = '0;
                        if (count_q != 8'hFF) count_d = count_q + 8'd1;
                        state_d    = SPAWN;
                    end else begin
                        offset_y_d = y_sum[9:0];
                    end
                end
            end
            FREEZE: begin
                if (frame_tick) begin
                    if (freeze_cnt_q == FCW'(1)) begin
                        state_d      = SPAWN;
                        frozen_d     = 1'b0;
                        active_d     = 1'b0;
                        offset_y_d   = '0;
                        freeze_cnt_d = '0;
                    end else begin
                        freeze_cnt_d = freeze_cnt_q - FCW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            offset_x_q   <= 10'(LANE_BASE);
            offset_y_q   <= '0;
            active_q     <= 1'b0;
            frozen_q     <= 1'b0;
            count_q      <= '0;
            prev_lane_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            offset_x_q   <= offset_x_d;
            offset_y_q   <= offset_y_d;
            active_q     <= active_d;
            frozen_q     <= frozen_d;
            count_q      <= count_d;
            prev_lane_q  <= prev_lane_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

`ifdef ENEMY_SPEEDUP_EN
    logic [3:0] speed_q;

    // Ramp on every SPEEDUP_EVERY-th completed pass; a collision restarts the ramp.
    always_ff @(posedge clk) begin
        if (reset) begin
            speed_q <= 4'(SPEED_INIT);
        end else if (state_q == FREEZE && state_d == SPAWN) begin
            speed_q <= 4'(SPEED_INIT);
        end else if (state_q == MOVE && state_d == SPAWN &&
                     (32'(count_d) % SPEEDUP_EVERY) == 0 && 32'(speed_q) < SPEED_MAX) begin
            speed_q <= speed_q + 4'd1;
        end
    end

    assign speed = speed_q;
`else
    assign speed = 4'(SPEED_INIT);
`endif

    assign bus.offset_x      = offset_x_q;
    assign bus.offset_y      = offset_y_q;
    assign bus.active        = active_q;
    assign bus.frozen        = frozen_q;
    assign bus.respawn_count = count_q;
endmodule

// File: tb/tb_enemy_motion_ctrl.sv
// Bench for enemy_motion_ctrl: directed scenarios plus random stimulus against a frame-level model.
// A second instance with a short screen (Y_LIMIT=16) reaches respawn saturation quickly.
module tb_enemy_motion_ctrl;
    localparam int Y_MAIN  = 480;
    localparam int Y_SMALL = 16;
`ifdef ENEMY_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif
    localparam int M_IDLE = 0, M_SPAWN = 1, M_MOVE = 2, M_FREEZE = 3;

    typedef struct {
        int         mode;
        int         ox;
        int         oy;
        bit         act;
        bit         frz;
        int         cnt;
        int         spd;
        int         prev;
        int         fcnt;
        bit         tick;
        logic [7:0] lfsr;
    } mdl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       collision = 1'b0;
    logic [9:0] hc = '0;
    logic [9:0] vc = '0;
    int         total = 0;
    int         bad = 0;
    mdl_t       m_main, m_small;
    logic [29:0] got_m, got_s;

    always #5 clk = ~clk;

    enemy_motion_ctrl_if bus_m ();
    enemy_motion_ctrl_if bus_s ();

    assign bus_m.start = start;
    assign bus_m.collision = collision;
    assign bus_m.hcount = hc;
    assign bus_m.vcount = vc;
    assign bus_s.start = start;
    assign bus_s.collision = collision;
    assign bus_s.hcount = hc;
    assign bus_s.vcount = vc;

    enemy_motion_ctrl dut_m (.clk(clk), .reset(reset), .bus(bus_m));
    enemy_motion_ctrl #(.Y_LIMIT(Y_SMALL)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));

    assign got_m = {bus_m.offset_x, bus_m.offset_y, bus_m.active, bus_m.frozen, bus_m.respawn_count};
    assign got_s = {bus_s.offset_x, bus_s.offset_y, bus_s.active, bus_s.frozen, bus_s.respawn_count};

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.mode = M_IDLE; m.ox = 160; m.oy = 0; m.act = 1'b0; m.frz = 1'b0;
        m.cnt = 0; m.spd = 2; m.prev = 0; m.fcnt = 0; m.tick = 1'b0; m.lfsr = 8'hA5;
        return m;
    endfunction

    // One clock of game rules, evaluated on the values held before the edge.
    function automatic mdl_t mdl_step(mdl_t m, bit rst, bit st, bit col, bit match, int ylim);
        mdl_t n;
        int lane;
        if (rst) return mdl_reset();
        n = m;
        n.tick = match;
        n.lfsr = {m.lfsr[6:0], m.lfsr[7] ^ m.lfsr[5] ^ m.lfsr[4] ^ m.lfsr[3]};
        case (m.mode)
            M_IDLE: if (st) n.mode = M_SPAWN;
            M_SPAWN: if (m.tick) begin
                lane = int'(m.lfsr[1:0]) % 3;
                if (lane == m.prev) lane = (lane + 1) % 3;
                n.ox = 160 + 120 * lane; n.oy = 0; n.act = 1'b1; n.prev = lane; n.mode = M_MOVE;
            end
            M_MOVE: if (col) begin
                n.mode = M_FREEZE; n.frz = 1'b1; n.fcnt = 60;
            end else if (m.tick) begin
                if (m.oy + m.spd >= ylim) begin
                    n.act = 1'b0; n.oy = 0; n.mode = M_SPAWN;
                    n.cnt = (m.cnt < 255) ? m.cnt + 1 : 255;
                    if (SPEEDUP && n.cnt % 4 == 0) n.spd = (m.spd < 8) ? m.spd + 1 : 8;
                end else begin
                    n.oy = m.oy + m.spd;
                end
            end
            M_FREEZE: if (m.tick) begin
                if (m.fcnt == 1) begin
                    n.mode = M_SPAWN; n.frz = 1'b0; n.act = 1'b0; n.oy = 0; n.spd = 2; n.fcnt = 0;
                end else begin
                    n.fcnt = m.fcnt - 1;
                end
            end
            default: n.mode = M_IDLE;
        endcase
        return n;
    endfunction

    function automatic logic [29:0] pack_m(mdl_t m);
        return {10'(m.ox), 10'(m.oy), m.act, m.frz, 8'(m.cnt)};
    endfunction

    task automatic step();
        bit match;
        @(posedge clk);
        match = (hc == 10'd640) && (vc == 10'd480);
        m_main  = mdl_step(m_main, reset, start, collision, match, Y_MAIN);
        m_small = mdl_step(m_small, reset, start, collision, match, Y_SMALL);
        #1;
    endtask

    task automatic set_in(input bit st, input bit col, input bit match);
        start = st;
        collision = col;
        if (match) begin
            hc = 10'd640;
            vc = 10'd480;
        end else begin
            hc = ($urandom_range(0, 2) == 0) ? 10'd640 : 10'($urandom_range(0, 799));
            vc = ($urandom_range(0, 2) == 0) ? 10'd480 : 10'($urandom_range(0, 524));
            if (hc == 10'd640 && vc == 10'd480) vc = 10'd479;
        end
    endtask

    // Corner seen on the first edge, tick acted on at the second.
    task automatic frame();
        set_in(1'b0, 1'b0, 1'b1);
        step();
        set_in(1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0);
        repeat (2) step();
        reset = 1'b0;
        total++; if (bus_m.offset_x !== 10'd160) begin bad++; $display("FAIL reset_offset_x got=%0d want=160", bus_m.offset_x); end
        total++; if (bus_m.offset_y !== 10'd0) begin bad++; $display("FAIL reset_offset_y got=%0d want=0", bus_m.offset_y); end
        total++; if (bus_m.active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", bus_m.active); end
        total++; if (bus_m.frozen !== 1'b0) begin bad++; $display("FAIL reset_frozen got=%b want=0", bus_m.frozen); end
        total++; if (bus_m.respawn_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus_m.respawn_count); end
        repeat (3) frame();
        total++; if (bus_m.active !== 1'b0 || bus_m.offset_y !== 10'd0) begin bad++; $display("FAIL idle_hold got=%b/%0d want=0/0", bus_m.active, bus_m.offset_y); end
    endtask

    task automatic test_start_move();
        set_in(1'b1, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b0);
        step();
        total++; if (bus_m.active !== 1'b0) begin bad++; $display("FAIL spawn_wait got=%b want=0", bus_m.active); end
        set_in(1'b0, 1'b0, 1'b1);
        step();
        set_in(1'b0, 1'b0, 1'b0);
        total++; if (bus_m.active !== 1'b0) begin bad++; $display("FAIL tick_latency got=%b want=0", bus_m.active); end
        step();
        total++; if (bus_m.active !== 1'b1 || bus_m.offset_y !== 10'd0) begin bad++; $display("FAIL spawn_active got=%b/%0d want=1/0", bus_m.active, bus_m.offset_y); end
        total++; if (got_m !== pack_m(m_main)) begin bad++; $display("FAIL spawn_lane got=%h want=%h", got_m, pack_m(m_main)); end
        for (int f = 1; f <= 2; f++) begin
            set_in(1'b0, 1'b0, 1'b1);
            step();
            set_in(1'b0, 1'b0, 1'b0);
            total++; if (bus_m.offset_y !== 10'(2 * (f - 1))) begin bad++; $display("FAIL move_hold got=%0d want=%0d", bus_m.offset_y, 2 * (f - 1)); end
            step();
            total++; if (bus_m.offset_y !== 10'(2 * f)) begin bad++; $display("FAIL move_step got=%0d want=%0d", bus_m.offset_y, 2 * f); end
            repeat (3) step();
            total++; if (bus_m.offset_y !== 10'(2 * f)) begin bad++; $display("FAIL move_gap got=%0d want=%0d", bus_m.offset_y, 2 * f); end
        end
    endtask

    task automatic test_midmove_reset();
        int n = 0;
        set_in(1'b0, 1'b0, 1'b1);
        while (bus_m.offset_y !== 10'd200 && n < 300) begin
            step();
            n++;
        end
        total++; if (n >= 300) begin bad++; $display("FAIL midmove_timeout got=%0d want=200", bus_m.offset_y); end
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        total++; if (bus_m.offset_x !== 10'd160) begin bad++; $display("FAIL midreset_x got=%0d want=160", bus_m.offset_x); end
        total++; if (bus_m.offset_y !== 10'd0) begin bad++; $display("FAIL midreset_y got=%0d want=0", bus_m.offset_y); end
        total++; if (bus_m.active !== 1'b0) begin bad++; $display("FAIL midreset_active got=%b want=0", bus_m.active); end
        set_in(1'b1, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b0);
        step();
        frame();
        total++; if (got_m !== pack_m(m_main)) begin bad++; $display("FAIL reseed_lane got=%h want=%h", got_m, pack_m(m_main)); end
    endtask

    task automatic test_respawn();
        int n = 0;
        int c0;
        logic [9:0] prev_x;
        set_in(1'b0, 1'b0, 1'b1);
        while (bus_m.offset_y !== 10'd478 && n < 400) begin
            step();
            n++;
        end
        total++; if (n >= 400) begin bad++; $display("FAIL edge_timeout got=%0d want=478", bus_m.offset_y); end
        prev_x = 10'(m_main.ox);
        c0 = m_main.cnt;
        set_in(1'b0, 1'b0, 1'b0);
        step();
        total++; if (bus_m.active !== 1'b0 || bus_m.offset_y !== 10'd0) begin bad++; $display("FAIL respawn_clear got=%b/%0d want=0/0", bus_m.active, bus_m.offset_y); end
        total++; if (bus_m.respawn_count !== 8'(c0 + 1)) begin bad++; $display("FAIL respawn_count got=%0d want=%0d", bus_m.respawn_count, c0 + 1); end
        frame();
        total++; if (bus_m.active !== 1'b1 || bus_m.offset_x === prev_x) begin bad++; $display("FAIL lane_change got=%b/%0d want=1/not %0d", bus_m.active, bus_m.offset_x, prev_x); end
        total++; if (got_m !== pack_m(m_main)) begin bad++; $display("FAIL respawn_model got=%h want=%h", got_m, pack_m(m_main)); end
    endtask

    task automatic test_collision();
        frame();
        frame();
        set_in(1'b0, 1'b0, 1'b1);
        step();
        set_in(1'b0, 1'b1, 1'b0);
        step();
        total++; if (bus_m.frozen !== 1'b1 || bus_m.active !== 1'b1) begin bad++; $display("FAIL freeze_enter got=%b/%b want=1/1", bus_m.frozen, bus_m.active); end
        total++; if (bus_m.offset_y !== 10'd4) begin bad++; $display("FAIL freeze_pos got=%0d want=4", bus_m.offset_y); end
        for (int k = 1; k <= 59; k++) begin
            set_in(k % 10 == 0, k % 7 == 0, 1'b1);
            step();
            set_in(1'b0, 1'b0, 1'b0);
            step();
        end
        total++; if (bus_m.frozen !== 1'b1 || bus_m.offset_y !== 10'd4) begin bad++; $display("FAIL freeze_hold got=%b/%0d want=1/4", bus_m.frozen, bus_m.offset_y); end
        frame();
        total++; if (bus_m.frozen !== 1'b0 || bus_m.active !== 1'b0 || bus_m.offset_y !== 10'd0) begin bad++; $display("FAIL freeze_exit got=%b/%b/%0d want=0/0/0", bus_m.frozen, bus_m.active, bus_m.offset_y); end
        frame();
        frame();
        total++; if (bus_m.offset_y !== 10'd2) begin bad++; $display("FAIL speed_reset got=%0d want=2", bus_m.offset_y); end
        total++; if (got_m !== pack_m(m_main)) begin bad++; $display("FAIL freeze_model got=%h want=%h", got_m, pack_m(m_main)); end
    endtask

    task automatic test_speed();
        int c0 = m_main.cnt;
        int n = 0;
        int want_spd;
        logic [9:0] last_y = bus_m.offset_y;
        set_in(1'b0, 1'b0, 1'b1);
        while (m_main.cnt < c0 + 28 && n < 20000) begin
            step();
            n++;
            total++; if (got_m !== pack_m(m_main)) begin bad++; $display("FAIL speed_track got=%h want=%h", got_m, pack_m(m_main)); end
            if (bus_m.offset_y > last_y) begin
                total++; if (int'(bus_m.offset_y - last_y) != m_main.spd) begin bad++; $display("FAIL speed_delta got=%0d want=%0d", bus_m.offset_y - last_y, m_main.spd); end
            end
            last_y = bus_m.offset_y;
        end
        total++; if (n >= 20000) begin bad++; $display("FAIL speed_timeout got=%0d want=%0d", m_main.cnt, c0 + 28); end
        want_spd = SPEEDUP ? 8 : 2;
        step();
        step();
        total++; if (bus_m.offset_y !== 10'(want_spd)) begin bad++; $display("FAIL speed_final got=%0d want=%0d", bus_m.offset_y, want_spd); end
        step();
        total++; if (bus_m.offset_y !== 10'(2 * want_spd)) begin bad++; $display("FAIL speed_stay got=%0d want=%0d", bus_m.offset_y, 2 * want_spd); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 999) == 0);
            set_in($urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
            step();
            total++; if (got_m !== pack_m(m_main)) begin bad++; $display("FAIL rand_main got=%h want=%h", got_m, pack_m(m_main)); end
            total++; if (got_s !== pack_m(m_small)) begin bad++; $display("FAIL rand_small got=%h want=%h", got_s, pack_m(m_small)); end
        end
        reset = 1'b0;
    endtask

    task automatic test_saturate();
        int n = 0;
        int c_end;
        while (m_small.cnt < 255 && n < 30000) begin
            set_in(n % 13 == 0, n == 500, 1'b1);
            step();
            n++;
            total++; if (got_s !== pack_m(m_small)) begin bad++; $display("FAIL sat_track got=%h want=%h", got_s, pack_m(m_small)); end
        end
        total++; if (n >= 30000) begin bad++; $display("FAIL sat_timeout got=%0d want=255", m_small.cnt); end
        c_end = 0;
        for (int i = 0; i < 60; i++) begin
            set_in(i % 3 == 0, 1'b0, 1'b1);
            step();
            if (m_small.mode == M_SPAWN && bus_s.active === 1'b0) c_end++;
            total++; if (bus_s.respawn_count !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d want=255", bus_s.respawn_count); end
        end
        total++; if (c_end == 0 || got_s !== pack_m(m_small)) begin bad++; $display("FAIL sat_more got=%h want=%h passes=%0d", got_s, pack_m(m_small), c_end); end
    endtask

    initial begin
        m_main = mdl_reset();
        m_small = mdl_reset();
        test_reset();
        test_start_move();
        test_midmove_reset();
        test_respawn();
        test_collision();
        test_speed();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
